// File: rtl/lfc_miss_frontend_if.sv
// lfc_miss_frontend_if: core request, bank lookup/MSHR/completion and flush signals
// of the lock-up-free cache front end. The slave modport is the front end itself and
// the master modport is the core/bank side. The perf_* members exist only when
// LFC_PERF_CNT_EN is defined.
interface lfc_miss_frontend_if #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned UUID_SIZE = 4
);
    // Core request and same-cycle hit return
    logic                                 req_valid;
    logic                                 req_ready;
    logic [31:0]                          req_addr;
    logic                                 req_rw;
    logic [31:0]                          req_store;
    logic [UUID_SIZE-1:0]                 req_uuid;
    logic                                 hit_valid;
    logic [31:0]                          hit_data;
    // Bank lookup
    logic [NUM_BANKS-1:0]                 bank_lookup;
    logic [NUM_BANKS-1:0]                 bank_hit;
    logic [NUM_BANKS-1:0][31:0]           bank_hit_data;
    // MSHR FIFO heads
    logic [NUM_BANKS-1:0]                 mshr_valid;
    logic [NUM_BANKS-1:0][31:0]           mshr_addr;
    logic [NUM_BANKS-1:0]                 mshr_rw;
    logic [NUM_BANKS-1:0][31:0]           mshr_store;
    logic [NUM_BANKS-1:0][UUID_SIZE-1:0]  mshr_uuid;
    logic [NUM_BANKS-1:0]                 mshr_pop;
    // Bank completions and merged response
    logic [NUM_BANKS-1:0]                 done_valid;
    logic [NUM_BANKS-1:0][UUID_SIZE-1:0]  done_uuid;
    logic [NUM_BANKS-1:0][31:0]           done_data;
    logic [NUM_BANKS-1:0]                 done_ready;
    logic                                 resp_valid;
    logic [UUID_SIZE-1:0]                 resp_uuid;
    logic [31:0]                          resp_data;
    // Halt / flush sequencing
    logic                                 halt;
    logic [NUM_BANKS-1:0]                 flush_req;
    logic [NUM_BANKS-1:0]                 bank_flushed;
    logic                                 flushed;
`ifdef LFC_PERF_CNT_EN
    logic [31:0]                          perf_hits;
    logic [31:0]                          perf_misses;
    logic [31:0]                          perf_stalls;
`endif

    modport slave (
        input  req_valid, req_addr, req_rw, req_store,
        input  bank_hit, bank_hit_data, mshr_pop,
        input  done_valid, done_uuid, done_data,
        input  halt, bank_flushed,
`ifdef LFC_PERF_CNT_EN
        output perf_hits, perf_misses, perf_stalls,
`endif
        output req_ready, req_uuid, hit_valid, hit_data, bank_lookup,
        output mshr_valid, mshr_addr, mshr_rw, mshr_store, mshr_uuid,
        output done_ready, resp_valid, resp_uuid, resp_data,
        output flush_req, flushed
    );

    modport master (
        output req_valid, req_addr, req_rw, req_store,
        output bank_hit, bank_hit_data, mshr_pop,
        output done_valid, done_uuid, done_data,
        output halt, bank_flushed,
`ifdef LFC_PERF_CNT_EN
        input  perf_hits, perf_misses, perf_stalls,
`endif
        input  req_ready, req_uuid, hit_valid, hit_data, bank_lookup,
        input  mshr_valid, mshr_addr, mshr_rw, mshr_store, mshr_uuid,
        input  done_ready, resp_valid, resp_uuid, resp_data,
        input  flush_req, flushed
    );
endinterface

// File: rtl/lfc_miss_frontend.sv
// lfc_miss_frontend: routes core requests to banks by address, returns hits in the
// same cycle, tags misses from a free-list and queues them in per-bank MSHR FIFOs,
// merges bank completions round-robin and sequences halt -> drain -> flush -> done.
// Optional feature: define LFC_PERF_CNT_EN to add saturating perf_hits, perf_misses
// and perf_stalls counters.
module lfc_miss_frontend #(
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned MSHR_DEPTH     = 4,
    parameter int unsigned UUID_SIZE      = 4,
    parameter int unsigned BYTE_OFF_BITS  = 2,
    parameter int unsigned BLOCK_OFF_BITS = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    lfc_miss_frontend_if.slave bus
);
    localparam int unsigned BankBits = $clog2(NUM_BANKS);
    localparam int unsigned IdxBits  = $clog2(MSHR_DEPTH);
    localparam int unsigned PtrBits  = IdxBits + 1;
    localparam int unsigned NumTags  = 2 ** UUID_SIZE;
    localparam int unsigned BankLsb  = BYTE_OFF_BITS + BLOCK_OFF_BITS;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 rw;
        logic [31:0]          store;
        logic [UUID_SIZE-1:0] uuid;
    } entry_t;

    typedef enum logic [1:0] {StRun, StDrain, StFlush, StDone} state_e;

    state_e               state_q;
    logic                 flush_req_q;
    logic                 flushed_q;
    // Low for the first cycle after reset release so req_ready rises one cycle late
    logic                 active_q;
    logic [NumTags-1:0]   free_q, free_d;
    logic [BankBits-1:0]  rr_q, rr_d;
    logic [PtrBits-1:0]   wr_ptr_q [NUM_BANKS];
    logic [PtrBits-1:0]   wr_ptr_d [NUM_BANKS];
    logic [PtrBits-1:0]   rd_ptr_q [NUM_BANKS];
    logic [PtrBits-1:0]   rd_ptr_d [NUM_BANKS];
    entry_t               mem_q    [NUM_BANKS][MSHR_DEPTH];

    logic [NUM_BANKS-1:0] empty, full, pop_en, grant;
    logic [BankBits-1:0]  req_bank, gnt_idx, scan_idx;
    logic [UUID_SIZE-1:0] alloc_uuid;
    logic                 run, hit, any_free, can_push, ready, push, found, drained;

    assign req_bank = bus.req_addr[BankLsb +: BankBits];
    assign run      = active_q && (state_q == StRun);

    // FIFO status; a pop is only honoured when the FIFO holds something
    always_comb begin
        drained = &free_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            empty[b]  = (wr_ptr_q[b] == rd_ptr_q[b]);
            full[b]   = (wr_ptr_q[b][IdxBits] != rd_ptr_q[b][IdxBits]) &&
                        (wr_ptr_q[b][IdxBits-1:0] == rd_ptr_q[b][IdxBits-1:0]);
            pop_en[b] = bus.mshr_pop[b] && !empty[b];
            drained   = drained && empty[b];
        end
    end

    // Lookup, lowest-free tag selection and accept decision
    always_comb begin
        alloc_uuid = '0;
        for (int i = int'(NumTags) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_uuid = UUID_SIZE'(i);
        end
        any_free = |free_q;
        hit      = run && bus.req_valid && bus.bank_hit[req_bank];
        // A same-cycle pop frees a slot even when the FIFO is full
        can_push = !full[req_bank] || pop_en[req_bank];
        ready    = run && (hit || (can_push && any_free));
        push     = bus.req_valid && ready && !hit;
        bus.bank_lookup = '0;
        if (bus.req_valid) bus.bank_lookup[req_bank] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign bus.req_uuid  = active_q ? alloc_uuid : '0;
    assign bus.hit_valid = hit;
    assign bus.hit_data  = hit ? bus.bank_hit_data[req_bank] : 32'd0;

    // Round-robin completion grant, highest priority just after the last winner
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            scan_idx = rr_q + BankBits'(k);
            if (active_q && !found && bus.done_valid[scan_idx]) begin
                found           = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    assign bus.done_ready = grant;
    assign bus.resp_valid = found;
    assign bus.resp_uuid  = found ? bus.done_uuid[gnt_idx] : '0;
    assign bus.resp_data  = found ? bus.done_data[gnt_idx] : 32'd0;

    // Free-list and arbiter pointer next state; allocation uses the pre-edge bitmap
    always_comb begin
        free_d = free_q;
        if (push)  free_d[alloc_uuid] = 1'b0;
        if (found) free_d[bus.done_uuid[gnt_idx]] = 1'b1;
        rr_d = found ? gnt_idx + BankBits'(1) : rr_q;
    end

    // Per-bank FIFO pointer next state
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_ptr_d[b] = wr_ptr_q[b];
            rd_ptr_d[b] = rd_ptr_q[b];
            if (push && (req_bank == BankBits'(b))) wr_ptr_d[b] = wr_ptr_q[b] + PtrBits'(1);
            if (pop_en[b]) rd_ptr_d[b] = rd_ptr_q[b] + PtrBits'(1);
        end
    end

    // FIFO head presentation; payload forced to zero while empty
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.mshr_valid[b] = !empty[b];
            bus.mshr_addr[b]  = empty[b] ? 32'd0 : mem_q[b][rd_ptr_q[b][IdxBits-1:0]].addr;
            bus.mshr_rw[b]    = empty[b] ? 1'b0  : mem_q[b][rd_ptr_q[b][IdxBits-1:0]].rw;
            bus.mshr_store[b] = empty[b] ? 32'd0 : mem_q[b][rd_ptr_q[b][IdxBits-1:0]].store;
            bus.mshr_uuid[b]  = empty[b] ? '0    : mem_q[b][rd_ptr_q[b][IdxBits-1:0]].uuid;
        end
    end

    // Control state: tags, arbiter pointer, FIFO pointers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            active_q <= 1'b0;
            free_q   <= '1;
            rr_q     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                wr_ptr_q[b] <= '0;
                rd_ptr_q[b] <= '0;
            end
        end else begin
            active_q <= 1'b1;
            free_q   <= free_d;
            rr_q     <= rr_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                wr_ptr_q[b] <= wr_ptr_d[b];
                rd_ptr_q[b] <= rd_ptr_d[b];
            end
        end
    end

    // FIFO storage; contents are qualified by the pointers so need no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[req_bank][wr_ptr_q[req_bank][IdxBits-1:0]] <=
                {bus.req_addr, bus.req_rw, bus.req_store, alloc_uuid};
        end
    end

    // Halt/drain/flush sequencer with registered flush outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StRun;
            flush_req_q <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.halt) state_q <= StDrain;
                end
                StDrain: begin
                    if (!bus.halt) begin
                        state_q <= StRun;
                    end else if (drained) begin
                        state_q     <= StFlush;
                        flush_req_q <= 1'b1;
                    end
                end
                StFlush: begin
                    if (&bus.bank_flushed) begin
                        state_q     <= StDone;
                        flush_req_q <= 1'b0;
                        flushed_q   <= 1'b1;
                    end
                end
                StDone: begin
                    flush_req_q <= 1'b0;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.flush_req = {NUM_BANKS{flush_req_q}};
    assign bus.flushed   = flushed_q;

`ifdef LFC_PERF_CNT_EN
    logic [31:0] perf_hits_q, perf_misses_q, perf_stalls_q;

    // Saturating event counters, frozen once the flush has completed
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_hits_q   <= 32'd0;
            perf_misses_q <= 32'd0;
            perf_stalls_q <= 32'd0;
        end else if (state_q != StDone) begin
            if (hit && (perf_hits_q != '1)) perf_hits_q <= perf_hits_q + 32'd1;
            if (push && (perf_misses_q != '1)) perf_misses_q <= perf_misses_q + 32'd1;
            if (bus.req_valid && !ready && (perf_stalls_q != '1)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign bus.perf_hits   = perf_hits_q;
    assign bus.perf_misses = perf_misses_q;
    assign bus.perf_stalls = perf_stalls_q;
`else
    // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_lfc_miss_frontend.sv
// Directed bench for lfc_miss_frontend: stimulus pushes expected hits, miss tags and
// merged responses into queues; a negedge monitor pops and compares them.
module tb_lfc_miss_frontend;
    localparam int unsigned NB = 4;
    localparam int unsigned UW = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    lfc_miss_frontend_if #(.NUM_BANKS(NB), .UUID_SIZE(UW)) bus ();

    lfc_miss_frontend #(
        .NUM_BANKS(NB), .MSHR_DEPTH(4), .UUID_SIZE(UW), .BYTE_OFF_BITS(2), .BLOCK_OFF_BITS(2)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
    );

    typedef struct packed {
        logic [UW-1:0] uuid;
        logic [31:0]   data;
        logic [NB-1:0] gnt;
    } resp_t;

    logic [31:0]   exp_hit_q [$];
    logic [UW-1:0] exp_uuid_q[$];
    resp_t         exp_resp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event with value 0x%0h, required no event", name, act);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle miss request; the monitor checks the tag when it is accepted
    task automatic issue_miss(input logic [31:0] addr, input logic [UW-1:0] uuid);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_rw    = addr[6];
        bus.req_store = ~addr;
        exp_uuid_q.push_back(uuid);
        tick();
        bus.req_valid = 1'b0;
    endtask

    // One-cycle completion from a single bank
    task automatic complete(input int b, input logic [UW-1:0] uuid, input logic [31:0] data);
        bus.done_valid    = '0;
        bus.done_valid[b] = 1'b1;
        bus.done_uuid[b]  = uuid;
        bus.done_data[b]  = data;
        exp_resp_q.push_back('{uuid: uuid, data: data, gnt: NB'(1) << b});
        tick();
        bus.done_valid = '0;
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.hit_valid) begin
                if (exp_hit_q.size() == 0) unexpected("hit", 64'(bus.hit_data));
                else check("hit_data", 64'(bus.hit_data), 64'(exp_hit_q.pop_front()));
            end
            if (bus.req_valid && bus.req_ready && !bus.hit_valid) begin
                if (exp_uuid_q.size() == 0) unexpected("miss_accept", 64'(bus.req_uuid));
                else check("req_uuid", 64'(bus.req_uuid), 64'(exp_uuid_q.pop_front()));
            end
            if (bus.resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    unexpected("resp", {bus.resp_uuid, bus.resp_data, bus.done_ready});
                end else begin
                    check("resp_uuid_data_grant", {bus.resp_uuid, bus.resp_data, bus.done_ready},
                          64'(exp_resp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_rw        = 1'b0;
        bus.req_store     = '0;
        bus.bank_hit      = '0;
        bus.bank_hit_data = '0;
        bus.mshr_pop      = '0;
        bus.done_valid    = '0;
        bus.done_uuid     = '0;
        bus.done_data     = '0;
        bus.halt          = 1'b0;
        bus.bank_flushed  = '0;

        // Reset state, with a hit and a completion presented during reset
        bus.req_valid        = 1'b1;
        bus.bank_hit         = 4'hF;
        bus.bank_hit_data[0] = 32'h1234;
        bus.done_valid       = 4'b0100;
        bus.done_data[2]     = 32'h77;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_hit_valid", 64'(bus.hit_valid), 64'd0);
        check("rst_hit_data", 64'(bus.hit_data), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_done_ready", 64'(bus.done_ready), 64'd0);
        check("rst_flushed", 64'(bus.flushed), 64'd0);
        check("rst_flush_req", 64'(bus.flush_req), 64'd0);
        check("rst_mshr_valid", 64'(bus.mshr_valid), 64'd0);
        bus.req_valid  = 1'b0;
        bus.bank_hit   = '0;
        bus.done_valid = '0;
        nRST = 1'b1;
        #1;
        check("ready_first_cycle", 64'(bus.req_ready), 64'd0);
        tick();
        check("ready_after_release", 64'(bus.req_ready), 64'd1);

        // Same-cycle hit on bank 1
        bus.req_valid        = 1'b1;
        bus.req_addr         = 32'h10;
        bus.bank_hit         = 4'b0010;
        bus.bank_hit_data[1] = 32'hDEAD;
        exp_hit_q.push_back(32'hDEAD);
        #1;
        check("bank_lookup", 64'(bus.bank_lookup), 64'b0010);
        tick();
        bus.req_valid = 1'b0;
        bus.bank_hit  = '0;

        // Four misses to bank 0 take tags 0..3 (the hit consumed none)
        issue_miss(32'h0, 4'd0);
        check("mshr_valid_after_miss", 64'(bus.mshr_valid), 64'b0001);
        check("mshr_uuid0_head", 64'(bus.mshr_uuid[0]), 64'd0);
        issue_miss(32'h40, 4'd1);
        issue_miss(32'h80, 4'd2);
        issue_miss(32'hC0, 4'd3);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h100;
        #1;
        check("ready_bank0_full", 64'(bus.req_ready), 64'd0);
        tick();
        bus.mshr_pop = 4'b0001;
        exp_uuid_q.push_back(4'd4);
        #1;
        check("ready_full_with_pop", 64'(bus.req_ready), 64'd1);
        tick();
        bus.mshr_pop  = '0;
        bus.req_valid = 1'b0;
        check("mshr_uuid0_after_pop", 64'(bus.mshr_uuid[0]), 64'd1);
        check("mshr_addr0_after_pop", 64'(bus.mshr_addr[0]), 64'h40);
        check("mshr_rw0_after_pop", 64'(bus.mshr_rw[0]), 64'd1);

        // Exhaust the tags across banks 1..3, leaving space in bank 3
        for (int k = 0; k < 4; k++) issue_miss(32'h10 + 32'(k) * 32'h40, UW'(5 + k));
        for (int k = 0; k < 4; k++) issue_miss(32'h20 + 32'(k) * 32'h40, UW'(9 + k));
        for (int k = 0; k < 3; k++) issue_miss(32'h30 + 32'(k) * 32'h40, UW'(13 + k));
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hF0;
        #1;
        check("ready_no_tags", 64'(bus.req_ready), 64'd0);
        tick();
        bus.done_valid[1] = 1'b1;
        bus.done_uuid[1]  = 4'd5;
        bus.done_data[1]  = 32'h55;
        exp_resp_q.push_back('{uuid: 4'd5, data: 32'h55, gnt: 4'b0010});
        #1;
        check("ready_same_cycle_free", 64'(bus.req_ready), 64'd0);
        tick();
        bus.done_valid = '0;
        exp_uuid_q.push_back(4'd5);
        #1;
        check("ready_after_free", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;

        // Round robin: bank 3 alone moves the pointer back to 0
        complete(3, 4'd13, 32'h1D);
        bus.done_valid   = 4'b1011;
        bus.done_uuid[0] = 4'd0;
        bus.done_data[0] = 32'hA0;
        bus.done_uuid[1] = 4'd6;
        bus.done_data[1] = 32'hA6;
        bus.done_uuid[3] = 4'd14;
        bus.done_data[3] = 32'hAE;
        exp_resp_q.push_back('{uuid: 4'd0, data: 32'hA0, gnt: 4'b0001});
        tick();
        bus.done_uuid[0] = 4'd1;
        bus.done_data[0] = 32'hA1;
        exp_resp_q.push_back('{uuid: 4'd6, data: 32'hA6, gnt: 4'b0010});
        tick();
        bus.done_valid = 4'b1001;
        exp_resp_q.push_back('{uuid: 4'd14, data: 32'hAE, gnt: 4'b1000});
        tick();
        bus.done_valid = 4'b0001;
        exp_resp_q.push_back('{uuid: 4'd1, data: 32'hA1, gnt: 4'b0001});
        tick();
        bus.done_valid = '0;

        // Asynchronous reset drops all queued misses at once
        check("mshr_valid_all_full", 64'(bus.mshr_valid), 64'hF);
        nRST = 1'b0;
        #1;
        check("async_rst_mshr_valid", 64'(bus.mshr_valid), 64'd0);
        check("async_rst_ready", 64'(bus.req_ready), 64'd0);
        tick();
        nRST = 1'b1;
        tick();
        issue_miss(32'h0, 4'd0);
        issue_miss(32'h20, 4'd1);

        // Halt with two outstanding misses; dropping halt in DRAIN returns to RUN
        bus.halt = 1'b1;
        tick();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h10;
        bus.bank_hit  = 4'b0010;
        #1;
        check("drain_hit_valid", 64'(bus.hit_valid), 64'd0);
        check("drain_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.bank_hit  = '0;
        bus.halt      = 1'b0;
        tick();
        check("run_after_unhalt", 64'(bus.req_ready), 64'd1);
        bus.halt = 1'b1;
        tick();
        bus.mshr_pop = 4'b0101;
        tick();
        bus.mshr_pop = '0;
        check("drain_fifos_empty", 64'(bus.mshr_valid), 64'd0);
        check("drain_flush_req_0", 64'(bus.flush_req), 64'd0);
        complete(0, 4'd0, 32'hB0);
        check("drain_one_left", 64'(bus.flush_req), 64'd0);
        complete(2, 4'd1, 32'hB1);
        check("drain_cond_cycle", 64'(bus.flush_req), 64'd0);
        tick();
        check("flush_req_all", 64'(bus.flush_req), 64'hF);
        check("flushed_in_flush", 64'(bus.flushed), 64'd0);
        bus.bank_flushed = 4'hF;
        tick();
        check("flushed_set", 64'(bus.flushed), 64'd1);
        check("flush_req_done", 64'(bus.flush_req), 64'd0);
        bus.halt         = 1'b0;
        bus.bank_flushed = '0;
        repeat (2) tick();
        check("flushed_sticky", 64'(bus.flushed), 64'd1);
        check("done_req_ready", 64'(bus.req_ready), 64'd0);

        @(negedge CLK);
        #1;
        check("hit_queue_empty", 64'(exp_hit_q.size()), 64'd0);
        check("uuid_queue_empty", 64'(exp_uuid_q.size()), 64'd0);
        check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
